if_stage: RTL and testbench



---
 rtl/if_pkg.sv | 26 ++
 rtl/if_stage_if.sv | 13 +
 rtl/if_perf_counters.sv | 23 ++
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } if_state_e;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // PC/instruction pair handed to the IF/ID register
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready handshake between fetch stage and memory.
interface if_stage_if;
  import if_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] rdata;
  logic            ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);

endinterface

// File: rtl/if_perf_counters.sv
// Fetch and stall event counters for the fetch stage; both wrap modulo 2^32.
module if_perf_counters
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_inc,
  input  logic            stall_inc,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] stall_count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_inc) fetch_count <= fetch_count + XLEN'(1);
      if (stall_inc) stall_count <= stall_count + XLEN'(1);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready, injects bubbles.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] Instruction,
  output logic            fetch_stall
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] stall_count
`endif
);

  if_state_e       state, state_n;
  logic [XLEN-1:0] pc_reg, pc_n;
  logic [XLEN-1:0] inst_buf, buf_n;
  logic [XLEN-1:0] hold_addr, hold_addr_n;
  logic [XLEN-1:0] target;
  if_id_t          out_c;

  assign target      = {branch_addr[XLEN-1:2], 2'b00};
  assign PC          = out_c.pc;
  assign Instruction = out_c.instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc_reg    <= RESET_PC;
      inst_buf  <= NOP_INSTR;
      hold_addr <= '0;
    end else begin
      state     <= state_n;
      pc_reg    <= pc_n;
      inst_buf  <= buf_n;
      hold_addr <= hold_addr_n;
    end
  end

  // Next state, PC update and fetch outputs; branch_taken overrides everything
  always_comb begin
    state_n     = state;
    pc_n        = pc_reg;
    buf_n       = inst_buf;
    hold_addr_n = hold_addr;
    imem.req    = 1'b0;
    imem.addr   = pc_reg;
    out_c       = '{pc: NOP_INSTR, instr: NOP_INSTR};
    fetch_stall = 1'b0;

    case (state)
      IDLE: begin
        state_n = FETCH;
        if (branch_taken) pc_n = target;
      end

      FETCH: begin
        imem.req    = 1'b1;
        fetch_stall = !imem.ready;
        if (branch_taken) begin
          pc_n = target;
          // Request still in flight: keep its address on the bus until ready
          if (!imem.ready) begin
            state_n     = DISCARD;
            hold_addr_n = pc_reg;
          end
        end else if (imem.ready) begin
          out_c = '{pc: next_pc(pc_reg), instr: imem.rdata};
          if (freeze) begin
            buf_n   = imem.rdata;
            state_n = HOLD;
          end else begin
            pc_n = next_pc(pc_reg);
          end
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_n    = target;
          buf_n   = NOP_INSTR;
          state_n = FETCH;
        end else begin
          out_c = '{pc: next_pc(pc_reg), instr: inst_buf};
          if (!freeze) begin
            pc_n    = next_pc(pc_reg);
            state_n = FETCH;
          end
        end
      end

      DISCARD: begin
        imem.req  = 1'b1;
        imem.addr = hold_addr;
        if (branch_taken) pc_n = target;
        else if (imem.ready) state_n = FETCH;
      end

      default: state_n = IDLE;
    endcase
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_accept;

  assign fetch_accept = (state == FETCH) && imem.ready && !branch_taken;

  if_perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc   (fetch_accept),
    .stall_inc   (fetch_stall),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage against a program-order fetch model.
module tb_if_stage;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        fetch_stall;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  if_stage_if imem ();

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem),
    .PC           (PC),
    .Instruction  (Instruction),
    .fetch_stall  (fetch_stall)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Program-order model: addresses the pipeline should receive next
  logic [31:0] exp_q[$];
  logic [31:0] tail_addr;

  // Memory/handshake model
  bit          busy;
  bit          squashed;
  int          wait_left;
  logic [31:0] lat_addr;
  logic        exp_stall;
  logic [31:0] exp_fc;
  logic [31:0] exp_sc;
  bit          mon_en;

  int unsigned max_wait;
  int unsigned frz_pct;
  int unsigned br_pct;
  int          frz_left;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    tail_addr = RST_PC;
    busy      = 1'b0;
    squashed  = 1'b0;
    wait_left = 0;
    lat_addr  = '0;
    exp_stall = 1'b0;
    exp_fc    = '0;
    exp_sc    = '0;
    frz_left  = 0;
  endtask

  // Memory with random wait states; also checks the req/addr stability rule
  task automatic mem_step();
    exp_stall = 1'b0;
    if (imem.req) begin
      check("addr_align", {30'b0, imem.addr[1:0]}, 32'h0);
      if (busy) begin
        check("hs_addr_stable", imem.addr, lat_addr);
      end else begin
        busy      = 1'b1;
        lat_addr  = imem.addr;
        wait_left = int'($urandom_range(max_wait, 0));
      end
      imem.ready = (wait_left == 0);
      imem.rdata = imem.ready ? mem_word(lat_addr) : $urandom;
      exp_stall  = !imem.ready && !squashed;
      if (imem.ready && !squashed && !branch_taken) exp_fc = exp_fc + 32'd1;
      if (exp_stall) exp_sc = exp_sc + 32'd1;
      if (imem.ready) begin
        busy     = 1'b0;
        squashed = squashed && branch_taken;
      end else begin
        wait_left--;
        if (branch_taken) squashed = 1'b1;
      end
    end else begin
      if (busy) check("hs_req_held", 32'(imem.req), 32'h1);
      busy       = 1'b0;
      imem.ready = 1'b0;
      imem.rdata = $urandom;
    end
  endtask

  // One cycle of stimulus, issued at the falling edge
  task automatic step();
    if (frz_left > 0) begin
      freeze = 1'b1;
      frz_left--;
    end else if ($urandom_range(99, 0) < frz_pct) begin
      freeze   = 1'b1;
      frz_left = int'($urandom_range(3, 0));
    end else begin
      freeze = 1'b0;
    end
    branch_taken = ($urandom_range(99, 0) < br_pct);
    if ($urandom_range(15, 0) == 0) branch_addr = 32'hFFFF_FFF8;
    else branch_addr = 32'($urandom_range(1023, 0)) << 2;
    mem_step();
    if (branch_taken) begin
      exp_q.delete();
      tail_addr = branch_addr;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(tail_addr);
      tail_addr = tail_addr + 32'd4;
    end
  endtask

  // Monitor: bubbles must be all-zero; valid outputs must follow program order
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && !rst) begin
        if (branch_taken) begin
          check("branch_bubble_instr", Instruction, NOP_INSTR);
          check("branch_bubble_pc", PC, 32'h0);
        end else if (Instruction != 32'h0) begin
          if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'h0, 32'h1);
          end else begin
            a = exp_q[0];
            check("pc", PC, a + 32'd4);
            check("instr", Instruction, mem_word(a));
            if (!freeze) void'(exp_q.pop_front());
          end
        end else begin
          check("bubble_pc", PC, 32'h0);
        end
        check("fetch_stall", 32'(fetch_stall), 32'(exp_stall));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem.req), 32'h0);
    check({tag, "_pc"}, PC, 32'h0);
    check({tag, "_instr"}, Instruction, 32'h0);
    check({tag, "_stall"}, 32'(fetch_stall), 32'h0);
`ifdef IF_PERF_CNT_EN
    check({tag, "_fcnt"}, fetch_count, 32'h0);
    check({tag, "_scnt"}, stall_count, 32'h0);
`endif
  endtask

  task automatic run_phase(input int unsigned mw, input int unsigned fp,
                           input int unsigned bp, input int cycles);
    max_wait = mw;
    frz_pct  = fp;
    br_pct   = bp;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      step();
    end
  endtask

  initial begin
    bit seen_req;
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem.ready   = 1'b0;
    imem.rdata   = '0;
    mon_en       = 1'b0;
    max_wait     = 0;
    frz_pct      = 0;
    br_pct       = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Zero-wait start-up: IDLE bubble, then addresses 0,4,8,... back to back
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    check("idle_req", 32'(imem.req), 32'h0);
    step();
    #1;
    check("idle_instr", Instruction, 32'h0);
    @(negedge clk);
    check("first_addr", imem.addr, RST_PC);
    step();
    #1;
    check("first_instr", Instruction, mem_word(RST_PC));
    check("first_pc", PC, RST_PC + 32'd4);
    run_phase(0, 0, 0, 6);

    run_phase(2, 0, 0, 60);
    run_phase(0, 20, 0, 200);
    run_phase(3, 10, 10, 400);
    run_phase(1, 25, 15, 400);

    // Reset pulsed while a request is on the bus
    seen_req = 1'b0;
    max_wait = 3;
    frz_pct  = 0;
    br_pct   = 0;
    for (int i = 0; i < 50 && !seen_req; i++) begin
      @(negedge clk);
      step();
      seen_req = imem.req;
    end
    check("midreset_req_seen", 32'(seen_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    check("post_reset_addr", imem.addr, RST_PC);
    step();

    run_phase(0, 0, 0, 10);
    run_phase(3, 15, 20, 400);
    run_phase(2, 30, 5, 400);
    run_phase(0, 10, 25, 400);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
`ifdef IF_PERF_CNT_EN
    check("fetch_count", fetch_count, exp_fc);
    check("stall_count", stall_count, exp_sc);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
